sw_seq_loader: RTL
==================

Name: sw_seq_loader

Overview:
Upstream feeder for the Smith-Waterman core (ref length 64, query length 48).
- Accepts host words packed with 2-bit nucleotides over a valid/ready handshake.
- Buffers one full reference and one full query.
- Replays them to the core as the core's `valid`/`data_ref`/`data_query` stream, then holds off the next job until the core raises `finish`.

Parameters:
- LEN_REF, 64, reference length in bases
- LEN_QUERY, 48, query length in bases (must be ≤ LEN_REF)
- IN_WIDTH, 8, host word width in bits; BPW = IN_WIDTH/2 bases per word; LEN_REF and LEN_QUERY must be multiples of BPW

Ports:
- clk  in  1  system clock; all state updates on rising edge
- reset  in  1  asynchronous, active-high; clears all control state and outputs
- start  in  1  single-cycle job request; honoured only in IDLE
- in_valid  in  1  host word valid
- in_ready  out  1  loader can accept a word (combinational from state only)
- in_data  in  IN_WIDTH  packed bases; base 0 in bits [1:0], base b in bits [2b+1:2b]
- sw_finish  in  1  core's finish output
- valid  out  1  drives core `valid`
- data_ref  out  2  drives core `data_ref`
- data_query  out  2  drives core `data_query`
- busy  out  1  high in every state except IDLE

Behaviour:
- Reset values: in_ready=0, valid=0, data_ref=0, data_query=0, busy=0, state=IDLE, all counters=0. Sequence buffers are not reset.
- Base encoding is A=0, C=1, G=2, T=3.
- States: IDLE, LOAD_REF, LOAD_QUERY, STREAM, WAIT_DONE.
- IDLE: in_ready=0. start=1 → LOAD_REF and word counter cleared.
- LOAD_REF: in_ready=1.
  - Each accepted word (in_valid & in_ready) writes bases [wc*BPW .. wc*BPW+BPW-1] of the ref buffer.
  - After LEN_REF/BPW words (16 at defaults) → LOAD_QUERY, wc cleared.
  - in_valid low simply stalls; there is no timeout.
- LOAD_QUERY: same rule into the query buffer. After LEN_QUERY/BPW words (12) → STREAM, stream counter k=0.
- STREAM: in_ready=0. Outputs are registered.
  - For k = 0..LEN_REF-1: valid=1, data_ref=R[k], data_query = (k<LEN_QUERY) ? Q[k] : 0.
  - valid rises on the edge after the edge that accepted the last query word.
  - valid stays high for exactly LEN_REF consecutive cycles, with no gaps.
  - After the final cycle: valid, data_ref and data_query return to 0 and the state goes → WAIT_DONE.
- WAIT_DONE: outputs held at 0. sw_finish=1 → IDLE on the next edge.
- sw_finish asserted in any state other than WAIT_DONE is ignored; it is not latched.
- start outside IDLE is ignored. start and sw_finish in the same WAIT_DONE cycle: go to IDLE only; start is not honoured.
- A new job overwrites both buffers in full. No partial reuse.
- Counters are sized for LEN_REF (7 bits at default). The stream counter never wraps inside a job.
- Reset asserted mid-job (any state) aborts immediately: outputs go to 0 asynchronously and the state returns to IDLE. Partially loaded data is discarded.
- Input-to-core latency per job: (LEN_REF + LEN_QUERY)/BPW accepted words, + 1 cycle, + LEN_REF streaming cycles.

Decomposition:
- Shared package sw_pkg:
  - base encoding constants;
  - LEN_REF/LEN_QUERY defaults;
  - scoring constants (match=2, mismatch=-1, gap open=2, gap extend=1);
  - loader state enum.
- One natural sub-module, sw_seq_buf: a word-write / base-read register file with parameters DEPTH and BPW. It is instantiated twice, once for ref and once for query.

Test Plan:
- Reset mid-STREAM at k=20 → valid, data_ref and data_query go to 0 immediately; state is IDLE. A fresh start then loads and streams normally.
- Ref words all 8'hE4 (bases 0,1,2,3 repeating) and query words all 8'h1B (bases 3,2,1,0 repeating), in_valid held high:
  - in_ready is high for 28 cycles;
  - valid is high for 64 cycles;
  - data_ref sequence is 0,1,2,3,...;
  - data_query is 3,2,1,0,... for k<48, then 0 for k=48..63.
- in_valid toggled every other cycle during load → exactly 16+12 words accepted; streamed bases identical to the back-to-back case.
- start pulsed during LOAD_QUERY and during STREAM → no effect; the stream still lasts exactly 64 valid cycles.
- sw_finish pulsed during STREAM, then again 5 cycles into WAIT_DONE → the first pulse is ignored; busy drops on the edge after the second pulse; the next start is accepted.

Source files
------------

// File: rtl/sw_pkg.sv
// Shared definitions for the Smith-Waterman front end: base encoding, default
// sequence lengths, scoring constants and the loader state encoding.
package sw_pkg;

  localparam int LEN_REF_DEF   = 64;
  localparam int LEN_QUERY_DEF = 48;
  localparam int IN_WIDTH_DEF  = 8;

  localparam logic [1:0] BASE_A = 2'd0;
  localparam logic [1:0] BASE_C = 2'd1;
  localparam logic [1:0] BASE_G = 2'd2;
  localparam logic [1:0] BASE_T = 2'd3;

  localparam int SCORE_MATCH    = 2;
  localparam int SCORE_MISMATCH = -1;
  localparam int GAP_OPEN       = 2;
  localparam int GAP_EXTEND     = 1;

  typedef enum logic [2:0] {
    IDLE,
    LOAD_REF,
    LOAD_QUERY,
    STREAM,
    WAIT_DONE
  } ld_state_e;

endpackage

// File: rtl/sw_seq_loader_if.sv
// Host-word intake and core-facing stream of the sequence loader.
interface sw_seq_loader_if #(
  parameter int IN_WIDTH = 8
);
  logic                start;
  logic                in_valid;
  logic                in_ready;
  logic [IN_WIDTH-1:0] in_data;
  logic                sw_finish;
  logic                valid;
  logic [1:0]          data_ref;
  logic [1:0]          data_query;
  logic                busy;

  modport master (
    output start, in_valid, in_data, sw_finish,
    input  in_ready, valid, data_ref, data_query, busy
  );

  modport slave (
    input  start, in_valid, in_data, sw_finish,
    output in_ready, valid, data_ref, data_query, busy
  );
endinterface

// File: rtl/sw_seq_buf.sv
// Sequence buffer: written a whole host word at a time, read one base at a time.
// Contents are deliberately unreset; every job rewrites all of it.
module sw_seq_buf #(
  parameter  int DEPTH = 64,
  parameter  int BPW   = 4,
  localparam int WORDS = DEPTH / BPW,
  localparam int WA_W  = $clog2(WORDS),
  localparam int RA_W  = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             we,
  input  logic [WA_W-1:0]  waddr,
  input  logic [2*BPW-1:0] wdata,
  input  logic [RA_W-1:0]  raddr,
  output logic [1:0]       rdata
);
  logic [WORDS-1:0][2*BPW-1:0] mem;
  logic [DEPTH-1:0][1:0]       bases;

  always_ff @(posedge clk)
    if (we) mem[waddr] <= wdata;

  // Same bits viewed base-wise: base b of word w lands at index w*BPW+b.
  assign bases = mem;
  assign rdata = bases[raddr];
endmodule

// File: rtl/sw_seq_loader.sv
// Loads one reference and one query from packed host words, replays them to the
// Smith-Waterman core as a registered base stream, then waits for the core's finish.
module sw_seq_loader import sw_pkg::*; #(
  parameter int LEN_REF   = LEN_REF_DEF,
  parameter int LEN_QUERY = LEN_QUERY_DEF,
  parameter int IN_WIDTH  = IN_WIDTH_DEF
) (
  input logic            clk,
  input logic            reset,
  sw_seq_loader_if.slave bus
);
  localparam int BPW       = IN_WIDTH / 2;
  localparam int WORDS_REF = LEN_REF / BPW;
  localparam int WORDS_QRY = LEN_QUERY / BPW;
  localparam int CNT_W     = $clog2(LEN_REF) + 1;
  localparam int WA_R      = $clog2(WORDS_REF);
  localparam int WA_Q      = $clog2(WORDS_QRY);
  localparam int RA_R      = $clog2(LEN_REF);
  localparam int RA_Q      = $clog2(LEN_QUERY);

  ld_state_e        state, state_n;
  logic [CNT_W-1:0] wc, wc_n, k, k_n;
  logic             valid_q, valid_n;
  logic [1:0]       ref_q, ref_n, qry_q, qry_n;
  logic [1:0]       ref_base, qry_base;
  logic             accept, we_ref, we_qry;

  assign bus.in_ready   = (state == LOAD_REF) || (state == LOAD_QUERY);
  assign bus.busy       = (state != IDLE);
  assign bus.valid      = valid_q;
  assign bus.data_ref   = ref_q;
  assign bus.data_query = qry_q;
  assign accept         = bus.in_valid && bus.in_ready;

  sw_seq_buf #(.DEPTH(LEN_REF), .BPW(BPW)) u_ref_buf (
    .clk   (clk),
    .we    (we_ref),
    .waddr (wc[WA_R-1:0]),
    .wdata (bus.in_data),
    .raddr (k[RA_R-1:0]),
    .rdata (ref_base)
  );

  sw_seq_buf #(.DEPTH(LEN_QUERY), .BPW(BPW)) u_qry_buf (
    .clk   (clk),
    .we    (we_qry),
    .waddr (wc[WA_Q-1:0]),
    .wdata (bus.in_data),
    .raddr (k[RA_Q-1:0]),
    .rdata (qry_base)
  );

  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      state   <= IDLE;
      wc      <= '0;
      k       <= '0;
      valid_q <= 1'b0;
      ref_q   <= BASE_A;
      qry_q   <= BASE_A;
    end else begin
      state   <= state_n;
      wc      <= wc_n;
      k       <= k_n;
      valid_q <= valid_n;
      ref_q   <= ref_n;
      qry_q   <= qry_n;
    end

  always_comb begin
    state_n = state;
    wc_n    = wc;
    k_n     = k;
    valid_n = 1'b0;
    ref_n   = BASE_A;
    qry_n   = BASE_A;
    we_ref  = 1'b0;
    we_qry  = 1'b0;
    case (state)
      IDLE:
        if (bus.start) begin
          state_n = LOAD_REF;
          wc_n    = '0;
        end
      LOAD_REF:
        if (accept) begin
          we_ref = 1'b1;
          if (wc == CNT_W'(WORDS_REF - 1)) begin
            state_n = LOAD_QUERY;
            wc_n    = '0;
          end else wc_n = wc + CNT_W'(1);
        end
      LOAD_QUERY:
        if (accept) begin
          we_qry = 1'b1;
          if (wc == CNT_W'(WORDS_QRY - 1)) begin
            state_n = STREAM;
            wc_n    = '0;
            k_n     = '0;
          end else wc_n = wc + CNT_W'(1);
        end
      STREAM: begin
        // Each edge here presents base k; the edge that presents the last base
        // already moves to WAIT_DONE, whose first edge drops the stream to 0.
        valid_n = 1'b1;
        ref_n   = ref_base;
        qry_n   = (k < CNT_W'(LEN_QUERY)) ? qry_base : BASE_A;
        if (k == CNT_W'(LEN_REF - 1)) begin
          state_n = WAIT_DONE;
          k_n     = '0;
        end else k_n = k + CNT_W'(1);
      end
      WAIT_DONE:
        if (bus.sw_finish) state_n = IDLE;
      default: state_n = IDLE;
    endcase
  end
endmodule
